// File: rtl/dfe_out_fifo_if.sv
// Sample stream bundle between the DFE core, the output FIFO and the downstream consumer.
// Carries the core-side push strobe with flags and the ready/valid output stream.
// slave = FIFO side, master = core/consumer side.
interface dfe_out_fifo_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         valid_in;
  logic signed [DATA_WIDTH-1:0] core_in;
  logic                         ovf_in;
  logic                         unf_in;
  logic                         out_ready;
  logic                         out_valid;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic [1:0]                   out_flags;

  modport slave (
    input  valid_in, core_in, ovf_in, unf_in, out_ready,
    output out_valid, out_data, out_flags
  );

  modport master (
    output valid_in, core_in, ovf_in, unf_in, out_ready,
    input  out_valid, out_data, out_flags
  );
endinterface

// File: rtl/dfe_out_fifo.sv
// Purpose: output FIFO behind the DFE core chain; stores samples with {unf, ovf} flags, counts drops.
// Latency: a push into an empty FIFO shows on out_valid/out_data one cycle later (registered show-ahead).
// Backpressure: out_ready stalls the head; the core cannot be stalled, so pushes into a full FIFO are dropped.
// Optional: define DFE_OUT_FIFO_HWM_EN to add the hwm (high-watermark of level) output.
module dfe_out_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 12,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  dfe_out_fifo_if.slave             io,
  input  logic                      flush,
  input  logic                      clr_stat,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      almost_full,
  output logic                      drop_sticky,
  output logic [CNT_WIDTH-1:0]      drop_cnt
`ifdef DFE_OUT_FIFO_HWM_EN
  ,
  output logic [$clog2(DEPTH):0]    hwm
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t                 state_q;
  logic [EW-1:0]          mem_q [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]          level_q, level_d;
  logic                   out_valid_q, out_valid_d;
  logic [EW-1:0]          out_ent_q, out_ent_d;
  logic                   drop_sticky_q, drop_sticky_d;
  logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;

  logic                   run_en;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic                   drop;
  logic [EW-1:0]          wr_ent;

  assign wr_ent = {io.unf_in, io.ovf_in, io.core_in};

  // Handshake decode, next pointers, next head entry and drop statistics.
  always_comb begin
    // Flush request cycle and the flush cycle itself both freeze push/pop and suppress drops.
    run_en   = (state_q == ST_RUN) && !flush;
    full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    pop      = run_en && out_valid_q && io.out_ready;
    push     = run_en && io.valid_in && (!full || pop);
    drop     = run_en && io.valid_in && full && !pop;

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = (state_q == ST_FLUSH) ? wr_ptr_q : rd_ptr_q + PW'(pop);
    level_d  = wr_ptr_d - rd_ptr_d;

    // Output register tracks the next head; the sample being written this cycle
    // is forwarded into it when it becomes the head (push into empty, or pop of the last entry).
    out_valid_d = (wr_ptr_d != rd_ptr_d);
    out_ent_d   = out_ent_q;
    if (out_valid_d) begin
      if (push && (rd_ptr_d == wr_ptr_q)) begin
        out_ent_d = wr_ent;
      end else begin
        out_ent_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end

    // Clear has priority over a coincident drop.
    drop_sticky_d = drop_sticky_q;
    drop_cnt_d    = drop_cnt_q;
    if (clr_stat) begin
      drop_sticky_d = 1'b0;
      drop_cnt_d    = '0;
    end else if (drop) begin
      drop_sticky_d = 1'b1;
      if (drop_cnt_q != {CNT_WIDTH{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // Flush FSM: one FLUSH cycle per request, re-entered while flush stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:   state_q <= flush ? ST_FLUSH : ST_RUN;
        ST_FLUSH: state_q <= flush ? ST_FLUSH : ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  // Sample storage; contents need no reset since pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_ent;
    end
  end

  // Pointers, level, registered head and drop statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      out_valid_q   <= 1'b0;
      out_ent_q     <= '0;
      drop_sticky_q <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      out_valid_q   <= out_valid_d;
      out_ent_q     <= out_ent_d;
      drop_sticky_q <= drop_sticky_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

`ifdef DFE_OUT_FIFO_HWM_EN
  logic [PW-1:0] hwm_q;

  // High-watermark follows the registered level; statistics clear and flush reset it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hwm_q <= '0;
    end else if (clr_stat || (state_q == ST_FLUSH)) begin
      hwm_q <= '0;
    end else if (level_q > hwm_q) begin
      hwm_q <= level_q;
    end
  end

  assign hwm = hwm_q;
`endif

  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_ent_q[DATA_WIDTH-1:0];
  assign io.out_flags = out_ent_q[EW-1 -: 2];
  assign level        = level_q;
  assign almost_full  = (level_q >= AF_LVL);
  assign drop_sticky  = drop_sticky_q;
  assign drop_cnt     = drop_cnt_q;

endmodule
